execute_stage_pipe: RTL and testbench

Parametrised, registered Y86 execute stage sitting between the decode and memory pipeline registers.
- Computes valE and the condition result Cnd, and owns the condition-code (CC) register.
- Adds ready/valid handshaking, a one-entry output register, a flush input and an optional iterative multiplier (mulq).
- The multiplier makes execute latency variable, so backpressure handling is mandatory.

---
 rtl/execute_stage_pipe_if.sv | 37 +++
 rtl/execute_stage_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_execute_stage_pipe.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_pipe_if.sv
// Handshake and data bundle between decode, the execute stage and memory.
// The master side is the decode/memory environment; the slave side is the stage.
interface execute_stage_pipe_if #(
    parameter int DATA_W = 64
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        icode_i;
    logic [3:0]        ifun_i;
    logic [DATA_W-1:0] valA_i;
    logic [DATA_W-1:0] valB_i;
    logic [DATA_W-1:0] valC_i;
    logic              set_cc_en_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [3:0]        out_icode_o;
    logic [DATA_W-1:0] out_valE_o;
    logic [DATA_W-1:0] out_valA_o;
    logic              out_cnd_o;
    logic [2:0]        cc_o;
    logic              busy_o;

    modport master (
        output in_valid_i, icode_i, ifun_i, valA_i, valB_i, valC_i,
               set_cc_en_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_icode_o, out_valE_o, out_valA_o,
               out_cnd_o, cc_o, busy_o
    );

    modport slave (
        input  in_valid_i, icode_i, ifun_i, valA_i, valB_i, valC_i,
               set_cc_en_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_icode_o, out_valE_o, out_valA_o,
               out_cnd_o, cc_o, busy_o
    );
endinterface

// File: rtl/execute_stage_pipe.sv
// Registered Y86 execute stage: computes valE and Cnd, owns the condition
// codes, buffers one result toward memory and runs an optional iterative
// shift-add multiplier for mulq, which makes latency variable.
module execute_stage_pipe #(
    parameter int DATA_W   = 64,
    parameter int STK_STEP = 8,
    parameter bit MUL_EN   = 1'b1
) (
    input logic            clk_i,
    input logic            rst_n_i,
    execute_stage_pipe_if.slave bus
);
    localparam int                 MSB      = DATA_W - 1;
    localparam int                 CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]  STEP     = DATA_W'(STK_STEP);

    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_ALU   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic               vld_p1;
    logic [3:0]         icode_p1;
    logic [DATA_W-1:0]  vale_p1;
    logic [DATA_W-1:0]  vala_p1;
    logic               cnd_p1;
    logic [2:0]         cc_q;           // {ZF, SF, OF}
    logic [CNT_W-1:0]   mul_cnt;
    logic [DATA_W-1:0]  mul_mcand;
    logic [DATA_W-1:0]  mul_mplier;
    logic [DATA_W-1:0]  mul_acc;
    logic [DATA_W-1:0]  mul_vala;
    logic [DATA_W-1:0]  mul_final;

    logic               out_free;
    logic               ready;
    logic               accept;
    logic               is_mul;
    logic               load_single;
    logic               alu_cc_upd;
    logic               mul_done;
    logic [DATA_W-1:0]  alu_res_p0;
    logic [DATA_W-1:0]  vale_p0;
    logic               ovf_p0;
    logic               cnd_p0;

    // ALU operation, valB op valA; undefined functions yield zero.
    function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] fn,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (fn)
            4'h0:    alu_op = b + a;
            4'h1:    alu_op = b - a;
            4'h2:    alu_op = b & a;
            4'h3:    alu_op = b ^ a;
            default: alu_op = '0;
        endcase
    endfunction

    // Two's-complement overflow for add and sub; logic ops never overflow.
    function automatic logic alu_ovf(input logic [3:0] fn,
                                     input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        case (fn)
            4'h0:    alu_ovf = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
            4'h1:    alu_ovf = (a[MSB] != b[MSB]) && (r[MSB] != b[MSB]);
            default: alu_ovf = 1'b0;
        endcase
    endfunction

    // Branch/cmov condition from the CC register.
    function automatic logic cond_met(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (fn)
            4'h0:    cond_met = 1'b1;
            4'h1:    cond_met = (sf ^ of) | zf;
            4'h2:    cond_met = sf ^ of;
            4'h3:    cond_met = zf;
            4'h4:    cond_met = !zf;
            4'h5:    cond_met = !(sf ^ of);
            4'h6:    cond_met = !(sf ^ of) && !zf;
            default: cond_met = 1'b0;
        endcase
    endfunction

    // valE selection by instruction class; arithmetic wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] exec_vale(input logic [3:0] ic,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [DATA_W-1:0] c,
                                                    input logic [DATA_W-1:0] alu_r);
        case (ic)
            I_ALU:            exec_vale = alu_r;
            I_RRMOV:          exec_vale = a;
            I_IRMOV:          exec_vale = c;
            I_RMMOV, I_MRMOV: exec_vale = b + c;
            I_PUSH, I_CALL:   exec_vale = b - STEP;
            I_POP, I_RET:     exec_vale = b + STEP;
            default:          exec_vale = '0;
        endcase
    endfunction

    // ---- stage p0: combinational execute of the presented instruction ----
    assign out_free    = !vld_p1 || bus.out_ready_i;
    assign ready       = (state_q == IDLE) && !bus.flush_i && out_free;
    assign accept      = bus.in_valid_i && ready;
    assign is_mul      = MUL_EN && (bus.icode_i == I_ALU) && (bus.ifun_i == 4'h4);
    assign load_single = accept && !is_mul;
    assign alu_cc_upd  = load_single && (bus.icode_i == I_ALU) && (bus.ifun_i <= 4'h3)
                         && bus.set_cc_en_i;
    assign alu_res_p0  = alu_op(bus.ifun_i, bus.valA_i, bus.valB_i);
    assign ovf_p0      = alu_ovf(bus.ifun_i, bus.valA_i, bus.valB_i, alu_res_p0);
    assign vale_p0     = exec_vale(bus.icode_i, bus.valA_i, bus.valB_i, bus.valC_i, alu_res_p0);
    assign cnd_p0      = ((bus.icode_i == I_RRMOV) || (bus.icode_i == I_JXX))
                         ? cond_met(bus.ifun_i, cc_q) : 1'b0;

    // The last multiplier step folds its partial product directly into the result.
    assign mul_final   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_done    = (state_q == MUL) && (mul_cnt == CNT_LAST) && out_free && !bus.flush_i;

    // Next-state logic: flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && is_mul) state_d = MUL;
                MUL:     if (mul_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---- stage p1: state, CC and output register ----
    // Control state, condition codes and the one-entry output register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            vld_p1   <= 1'b0;
            icode_p1 <= '0;
            vale_p1  <= '0;
            vala_p1  <= '0;
            cnd_p1   <= 1'b0;
            cc_q     <= 3'b100;
            mul_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && is_mul) begin
                mul_cnt <= '0;
            end else if ((state_q == MUL) && (mul_cnt != CNT_LAST)) begin
                mul_cnt <= mul_cnt + 1'b1;
            end
            if (bus.flush_i) begin
                vld_p1 <= 1'b0;
            end else if (load_single) begin
                vld_p1   <= 1'b1;
                icode_p1 <= bus.icode_i;
                vale_p1  <= vale_p0;
                vala_p1  <= bus.valA_i;
                cnd_p1   <= cnd_p0;
            end else if (mul_done) begin
                vld_p1   <= 1'b1;
                icode_p1 <= I_ALU;
                vale_p1  <= mul_final;
                vala_p1  <= mul_vala;
                cnd_p1   <= 1'b0;
            end else if (bus.out_ready_i) begin
                vld_p1 <= 1'b0;
            end
            if (alu_cc_upd) begin
                cc_q <= {alu_res_p0 == '0, alu_res_p0[MSB], ovf_p0};
            end else if (mul_done && bus.set_cc_en_i) begin
                cc_q <= {mul_final == '0, mul_final[MSB], 1'b0};
            end
        end
    end

    // Shift-add multiplier datapath: one multiplier bit consumed per cycle.
    always_ff @(posedge clk_i) begin
        if (accept && is_mul) begin
            mul_mcand  <= bus.valA_i;
            mul_mplier <= bus.valB_i;
            mul_acc    <= '0;
            mul_vala   <= bus.valA_i;
        end else if ((state_q == MUL) && (mul_cnt != CNT_LAST)) begin
            mul_acc    <= mul_acc + (mul_mplier[0] ? mul_mcand : '0);
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
        end
    end

    assign bus.in_ready_o  = ready;
    assign bus.out_valid_o = vld_p1;
    assign bus.out_icode_o = icode_p1;
    assign bus.out_valE_o  = vale_p1;
    assign bus.out_valA_o  = vala_p1;
    assign bus.out_cnd_o   = cnd_p1;
    assign bus.cc_o        = cc_q;
    assign bus.busy_o      = (state_q == MUL);
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Bench for execute_stage_pipe: directed scenarios plus randomized traffic
// on a 64-bit instance against a transaction-level model, and a 16-bit
// instance for stack wrap and short multiplies.
module tb_execute_stage_pipe;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_stage_pipe_if #(.DATA_W(64)) bus ();
    execute_stage_pipe_if #(.DATA_W(16)) bus16 ();

    execute_stage_pipe #(.DATA_W(64), .STK_STEP(8), .MUL_EN(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus));
    execute_stage_pipe #(.DATA_W(16), .STK_STEP(8), .MUL_EN(1'b1)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus16));

    int checks = 0;
    int failures = 0;

    // Model of the stage: one buffered result, remaining multiply cycles, CC.
    logic        m_ov;
    logic [3:0]  m_icode;
    logic [63:0] m_vale, m_vala;
    logic        m_cnd;
    int          m_left;
    logic [63:0] m_mres, m_ma;
    logic [2:0]  m_cc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ov = 1'b0; m_icode = '0; m_vale = '0; m_vala = '0; m_cnd = 1'b0;
        m_left = 0; m_mres = '0; m_ma = '0; m_cc = 3'b100;
    endtask

    function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (ic)
            4'h6: begin
                case (fn)
                    4'h0: return b + a;
                    4'h1: return b - a;
                    4'h2: return b & a;
                    4'h3: return b ^ a;
                    default: return 64'd0;
                endcase
            end
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of, lt;
        zf = cc[2]; sf = cc[1]; of = cc[0]; lt = sf ^ of;
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        case (fn)
            4'h0: return 1'b1;
            4'h1: return lt || zf;
            4'h2: return lt;
            4'h3: return zf;
            4'h4: return !zf;
            4'h5: return !lt;
            4'h6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] ref_cc(input logic [3:0] fn, input logic [63:0] a,
                                          input logic [63:0] b, input logic [2:0] cc);
        logic [63:0] r;
        logic of;
        if (fn > 4'h3) return cc;
        r = ref_vale(4'h6, fn, a, b, 64'd0);
        of = 1'b0;
        if (fn == 4'h0) of = (a[63] == b[63]) && (r[63] != a[63]);
        if (fn == 4'h1) of = (a[63] != b[63]) && (r[63] != b[63]);
        return {r == 64'd0, r[63], of};
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // One clock cycle on the 64-bit instance: drive, compare with model, advance model.
    task automatic cycle(input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic sc, input logic fl, input logic ordy);
        logic exp_rdy, acc, ld, consumed;
        logic [3:0] n_ic;
        logic [63:0] n_ve, n_va;
        logic n_cnd;
        bus.in_valid_i = iv; bus.icode_i = ic; bus.ifun_i = fn;
        bus.valA_i = a; bus.valB_i = b; bus.valC_i = c;
        bus.set_cc_en_i = sc; bus.flush_i = fl; bus.out_ready_i = ordy;
        @(negedge clk);
        exp_rdy = (m_left == 0) && !fl && (!m_ov || ordy);
        check_val("in_ready", 64'(bus.in_ready_o), 64'(exp_rdy));
        check_val("out_valid", 64'(bus.out_valid_o), 64'(m_ov));
        check_val("busy", 64'(bus.busy_o), 64'(m_left != 0));
        check_val("cc", 64'(bus.cc_o), 64'(m_cc));
        if (m_ov) begin
            check_val("out_icode", 64'(bus.out_icode_o), 64'(m_icode));
            check_val("out_valE", bus.out_valE_o, m_vale);
            check_val("out_valA", bus.out_valA_o, m_vala);
            check_val("out_cnd", 64'(bus.out_cnd_o), 64'(m_cnd));
        end
        acc = iv && exp_rdy;
        n_ic = '0; n_ve = '0; n_va = '0; n_cnd = 1'b0;
        if (fl) begin
            m_ov = 1'b0;
            m_left = 0;
        end else begin
            ld = 1'b0;
            consumed = m_ov && ordy;
            if (m_left > 1) begin
                m_left--;
            end else if (m_left == 1 && (!m_ov || ordy)) begin
                ld = 1'b1; n_ic = 4'h6; n_ve = m_mres; n_va = m_ma; n_cnd = 1'b0;
                if (sc) m_cc = {m_mres == 64'd0, m_mres[63], 1'b0};
                m_left = 0;
            end
            if (acc) begin
                if (ic == 4'h6 && fn == 4'h4) begin
                    m_left = W;
                    m_mres = a * b;
                    m_ma = a;
                end else begin
                    ld = 1'b1; n_ic = ic; n_ve = ref_vale(ic, fn, a, b, c); n_va = a;
                    n_cnd = ref_cnd(ic, fn, m_cc);
                    if (ic == 4'h6 && sc) m_cc = ref_cc(fn, a, b, m_cc);
                end
            end
            if (ld) begin
                m_ov = 1'b1; m_icode = n_ic; m_vale = n_ve; m_vala = n_va; m_cnd = n_cnd;
            end else if (consumed) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, ordy);
    endtask

    initial begin
        int bc, done_k;
        logic seen;
        logic [3:0] ic, fn;
        model_reset();
        bus.in_valid_i = 0; bus.icode_i = 0; bus.ifun_i = 0; bus.valA_i = 0; bus.valB_i = 0;
        bus.valC_i = 0; bus.set_cc_en_i = 1; bus.flush_i = 0; bus.out_ready_i = 1;
        bus16.in_valid_i = 0; bus16.icode_i = 0; bus16.ifun_i = 0; bus16.valA_i = 0;
        bus16.valB_i = 0; bus16.valC_i = 0; bus16.set_cc_en_i = 1; bus16.flush_i = 0;
        bus16.out_ready_i = 1;

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        check_val("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check_val("rst_cc", 64'(bus.cc_o), 64'b100);
        check_val("rst_busy", 64'(bus.busy_o), 64'd0);
        check_val("rst_valE", bus.out_valE_o, 64'd0);
        rst_n = 1'b1;
        idle(1'b1);

        // irmov, subq, jle, jg
        cycle(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'd5, 1, 0, 1);
        check_val("irmov_valid", 64'(bus.out_valid_o), 64'd1);
        check_val("irmov_valE", bus.out_valE_o, 64'd5);
        cycle(1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1, 0, 1);
        check_val("subq_valE", bus.out_valE_o, 64'd0);
        check_val("subq_cc", 64'(bus.cc_o), 64'b100);
        cycle(1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1, 0, 1);
        check_val("jle_cnd", 64'(bus.out_cnd_o), 64'd1);
        cycle(1, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1, 0, 1);
        check_val("jg_cnd", 64'(bus.out_cnd_o), 64'd0);

        // Signed overflow, then suppressed CC update
        cycle(1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 1);
        check_val("addov_valE", bus.out_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("addov_cc", 64'(bus.cc_o), 64'b011);
        cycle(1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1, 0, 1);
        cycle(1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 1);
        check_val("addov_nocc_valE", bus.out_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("addov_nocc_cc", 64'(bus.cc_o), 64'b100);

        // Backpressure: result held, input stalled, then delivered
        cycle(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'd11, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'd22, 1, 0, 0);
            check_val("bp_hold_valE", bus.out_valE_o, 64'd11);
        end
        cycle(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'd22, 1, 0, 1);
        check_val("bp_next_valE", bus.out_valE_o, 64'd22);
        idle(1'b1);

        // mulq 7*6 latency and result
        cycle(1, 4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 1, 0, 1);
        bc = 0; done_k = 0;
        for (int k = 1; k <= 80; k++) begin
            if (bus.out_valid_o) begin
                done_k = k;
                break;
            end
            if (bus.busy_o) bc++;
            idle(1'b1);
        end
        check_val("mul_latency", 64'(done_k), 64'd65);
        check_val("mul_busy_cycles", 64'(bc), 64'd64);
        check_val("mul_valE", bus.out_valE_o, 64'd42);
        check_val("mul_cc", 64'(bus.cc_o), 64'b000);
        idle(1'b1);

        // mulq aborted by flush in its tenth cycle
        cycle(1, 4'h6, 4'h4, 64'd3, 64'd5, 64'd0, 1, 0, 1);
        for (int k = 1; k < 10; k++) idle(1'b1);
        cycle(0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1, 1, 1);
        seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            seen = seen | bus.out_valid_o;
            idle(1'b1);
        end
        check_val("flush_no_out", 64'(seen), 64'd0);
        check_val("flush_cc", 64'(bus.cc_o), 64'b000);

        // Asynchronous reset in the middle of a multiply
        cycle(1, 4'h6, 4'h4, 64'd9, 64'd9, 64'd0, 1, 0, 1);
        for (int k = 0; k < 5; k++) idle(1'b1);
        rst_n = 1'b0;
        #1;
        check_val("rstmul_busy", 64'(bus.busy_o), 64'd0);
        check_val("rstmul_valid", 64'(bus.out_valid_o), 64'd0);
        check_val("rstmul_cc", 64'(bus.cc_o), 64'b100);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            ic = ($urandom_range(0, 9) < 4) ? 4'h6 : 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 8));
            if (ic == 4'h6 && fn == 4'h4 && $urandom_range(0, 7) != 0) fn = 4'h1;
            cycle($urandom_range(0, 9) < 7, ic, fn, rnd_val(), rnd_val(), rnd_val(),
                  $urandom_range(0, 19) < 17, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 70; k++) idle(1'b1);

        // 16-bit instance: push/pop wrap and a short multiply
        bus16.in_valid_i = 1; bus16.icode_i = 4'hA; bus16.valB_i = 16'h0100;
        @(posedge clk); #1;
        check_val("w16_push_valid", 64'(bus16.out_valid_o), 64'd1);
        check_val("w16_push_valE", 64'(bus16.out_valE_o), 64'h00F8);
        bus16.icode_i = 4'hB; bus16.valB_i = 16'hFFFC;
        @(posedge clk); #1;
        check_val("w16_pop_valE", 64'(bus16.out_valE_o), 64'h0004);
        bus16.icode_i = 4'h6; bus16.ifun_i = 4'h4; bus16.valA_i = 16'd300; bus16.valB_i = 16'd300;
        @(posedge clk); #1;
        bus16.in_valid_i = 0;
        done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus16.out_valid_o) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("w16_mul_latency", 64'(done_k), 64'd17);
        check_val("w16_mul_valE", 64'(bus16.out_valE_o), 64'h5F90);
        check_val("w16_mul_cc", 64'(bus16.cc_o), 64'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
